// File: rtl/coleta_8_num.sv
// Collects eight unsigned bytes from a valid/ready stream into one packed frame for the 8-number sorter.
// Optional short frames with direction-dependent padding: define COLETA_PAD_EN.
module coleta_8_num #(
    parameter int         N_NUM      = 8,
    parameter logic [7:0] PAD_CRESC  = 8'hFF,
    parameter logic [7:0] PAD_DECRES = 8'h00
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data,
    input  logic            in_last,
    input  logic            in_cresc,
    output logic [7:0][7:0] desordenado,
    output logic            cresc_ou_decres,
    output logic            ena,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      count
);

`ifdef COLETA_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam logic [2:0] LAST_IDX = 3'(N_NUM - 1);

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t     state, state_nxt;
    logic [2:0] idx;
    logic       hs;
    logic       last_hs;
    logic       dir;
    logic [7:0] pad_val;
    logic [7:0] pad_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state != FULL);
        out_valid = (state == FULL);
        hs        = in_valid && in_ready;
        last_hs   = hs && ((idx == LAST_IDX) || (PAD_EN && in_last));
        case (state)
            IDLE: if (hs) state_nxt = last_hs ? FULL : FILL;
            FILL: if (last_hs) state_nxt = FULL;
            FULL: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ena = out_valid;

    // The direction for padding must be the one this frame latches, even on its first byte.
    always_comb begin
        dir      = (state == IDLE) ? in_cresc : cresc_ou_decres;
        pad_val  = dir ? PAD_CRESC : PAD_DECRES;
        pad_mask = '0;
        for (int i = 0; i < 8; i++) pad_mask[i] = (i > int'(idx));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx             <= '0;
            desordenado     <= '0;
            cresc_ou_decres <= 1'b1;
            count           <= '0;
        end else if (hs) begin
            desordenado[idx] <= in_data;
            if (state == IDLE) cresc_ou_decres <= in_cresc;
            if (last_hs) begin
                idx   <= '0;
                count <= {1'b0, idx} + 4'd1;
                for (int i = 0; i < 8; i++)
                    if (pad_mask[i]) desordenado[i] <= pad_val;
            end else begin
                idx <= idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_coleta_8_num.sv
// Directed self-checking bench for coleta_8_num; inputs change and outputs are sampled on the falling edge.
module tb_coleta_8_num;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_data;
    logic            in_last;
    logic            in_cresc;
    logic [7:0][7:0] desordenado;
    logic            cresc_ou_decres;
    logic            ena;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    coleta_8_num dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_cresc(in_cresc),
        .desordenado(desordenado), .cresc_ou_decres(cresc_ou_decres),
        .ena(ena), .out_valid(out_valid), .out_ready(out_ready), .count(count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; the byte is offered across the next rising edge.
    task automatic send(input logic [7:0] d, input logic c, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_cresc = c;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_cresc = 1'b0; out_ready = 1'b0;

        // reset
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_ena", ena, 1'b0);
        check("rst_frame", desordenado, 64'h0);
        check("rst_count", count, 4'd0);
        check("rst_dir", cresc_ou_decres, 1'b1);

        // full frame, ascending
        send(8'd5, 1'b1, 1'b0); send(8'd3, 1'b1, 1'b0); send(8'd9, 1'b1, 1'b0);
        send(8'd1, 1'b1, 1'b0); send(8'd8, 1'b1, 1'b0); send(8'd2, 1'b1, 1'b0);
        send(8'd7, 1'b1, 1'b0);
        check("fill7_out_valid", out_valid, 1'b0);
        check("fill7_in_ready", in_ready, 1'b1);
        send(8'd4, 1'b1, 1'b0);
        check("full_out_valid", out_valid, 1'b1);
        check("full_ena", ena, 1'b1);
        check("full_in_ready", in_ready, 1'b0);
        check("full_frame", desordenado, 64'h0407020801090305);
        check("full_dir", cresc_ou_decres, 1'b1);
        check("full_count", count, 4'd8);

        // backpressure with a byte waiting
        in_valid = 1'b1; in_data = 8'hAA; in_cresc = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_frame", desordenado, 64'h0407020801090305);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("rel_out_valid", out_valid, 1'b0);
        check("rel_in_ready", in_ready, 1'b1);
        check("rel_frame_held", desordenado, 64'h0407020801090305);
        check("rel_count_held", count, 4'd8);
        @(negedge clk);
        in_valid = 1'b0;
        check("aa_slot0", desordenado, 64'h04070208010903AA);
        check("aa_dir", cresc_ou_decres, 1'b0);

        // remaining bytes with in_cresc toggling
        for (int i = 0; i < 7; i++) begin
            logic [7:0] d;
            d = 8'h10 + 8'(i);
            send(d, ~i[0], 1'b0);
            if (i == 2) begin
                check("mid_dir", cresc_ou_decres, 1'b0);
                check("mid_out_valid", out_valid, 1'b0);
            end
        end
        check("dir_out_valid", out_valid, 1'b1);
        check("dir_frame", desordenado, 64'h16151413121110AA);
        check("dir_latched", cresc_ou_decres, 1'b0);
        check("dir_count", count, 4'd8);
        ack();
        check("ack_out_valid", out_valid, 1'b0);

        // out_ready while not full is ignored
        out_ready = 1'b1;
        send(8'h21, 1'b1, 1'b0); send(8'h22, 1'b1, 1'b0);
        send(8'h23, 1'b1, 1'b0); send(8'h24, 1'b1, 1'b0);
        out_ready = 1'b0;
        check("part_out_valid", out_valid, 1'b0);
        check("part_in_ready", in_ready, 1'b1);

        // reset mid-frame
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_frame", desordenado, 64'h0);
        check("mrst_count", count, 4'd0);
        check("mrst_dir", cresc_ou_decres, 1'b1);
        check("mrst_out_valid", out_valid, 1'b0);
        send(8'h31, 1'b0, 1'b0); send(8'h32, 1'b0, 1'b0);
`ifdef COLETA_PAD_EN
        send(8'h33, 1'b0, 1'b0);
`else
        send(8'h33, 1'b0, 1'b1);
        check("last_ignored", out_valid, 1'b0);
`endif
        send(8'h34, 1'b0, 1'b0); send(8'h35, 1'b0, 1'b0); send(8'h36, 1'b0, 1'b0);
        send(8'h37, 1'b0, 1'b0); send(8'h38, 1'b0, 1'b0);
        check("fresh_out_valid", out_valid, 1'b1);
        check("fresh_frame", desordenado, 64'h3837363534333231);
        check("fresh_dir", cresc_ou_decres, 1'b0);
        check("fresh_count", count, 4'd8);
        ack();

`ifdef COLETA_PAD_EN
        send(8'd6, 1'b1, 1'b0); send(8'd2, 1'b1, 1'b0); send(8'd4, 1'b1, 1'b1);
        check("pad_up_valid", out_valid, 1'b1);
        check("pad_up_frame", desordenado, 64'hFFFFFFFFFF040206);
        check("pad_up_count", count, 4'd3);
        ack();
        send(8'd6, 1'b0, 1'b0); send(8'd2, 1'b0, 1'b0); send(8'd4, 1'b0, 1'b1);
        check("pad_dn_valid", out_valid, 1'b1);
        check("pad_dn_frame", desordenado, 64'h0000000000040206);
        check("pad_dn_count", count, 4'd3);
        ack();
        send(8'h77, 1'b1, 1'b1);
        check("pad_one_frame", desordenado, 64'hFFFFFFFFFFFFFF77);
        check("pad_one_count", count, 4'd1);
        ack();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/coleta_8_num.md
# coleta_8_num

Upstream collector for the 8-number sorter. It accepts unsigned bytes one per handshake on a valid/ready stream and assembles them into one packed 8 x 8-bit frame. It latches the sort direction per frame and presents the frame, with `ena`, directly to the sorter inputs. The frame is held stable until the downstream consumer acknowledges it.

## Interface
Parameters:
- `N_NUM`, 8: slots per frame. Fixed at 8 to match the sorter; other values are unsupported.
- `PAD_CRESC`, 8'hFF: pad value when the latched direction is ascending (only with `COLETA_PAD_EN`).
- `PAD_DECRES`, 8'h00: pad value when the latched direction is descending (only with `COLETA_PAD_EN`).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  collector can accept a byte.
- `in_data`  in  8  unsigned input byte.
- `in_last`  in  1  marks the final byte of a short frame (only with `COLETA_PAD_EN`; otherwise ignored).
- `in_cresc`  in  1  sort direction, 1 = ascending, 0 = descending. Sampled with the first byte of a frame.
- `desordenado`  out  [7:0][7:0]  assembled frame; slot 0 holds the first accepted byte.
- `cresc_ou_decres`  out  1  latched direction for the current frame.
- `ena`  out  1  sorter enable; equal to `out_valid`.
- `out_valid`  out  1  frame complete and stable.
- `out_ready`  in  1  consumer accepts the frame.
- `count`  out  4  number of real (non-pad) bytes in the frame, 1..8.

## Operation
- States:
  - IDLE: empty; `in_ready`=1.
  - FILL: 1..7 slots written; `in_ready`=1.
  - FULL: `out_valid`=1; `in_ready`=0.
- An input handshake occurs when `in_valid` and `in_ready` are both high.
  - Each handshake writes `in_data` into slot `idx` and increments `idx`, a 3-bit write index.
  - In IDLE, a handshake also latches `in_cresc` into `cresc_ou_decres`, and the state moves to FILL.
- Completing a frame:
  - The 8th handshake (`idx`=7) moves the state to FULL and sets `count`=8.
  - `idx` wraps to 0.
- Leaving FULL:
  - `out_valid` && `out_ready` returns the state to IDLE.
  - `desordenado`, `cresc_ou_decres` and `count` keep their values until the next frame overwrites them.
- Stability in FULL: `desordenado`, `cresc_ou_decres` and `count` do not change while `out_valid`=1.
- `in_cresc` changes in mid-frame have no effect.
- `ena`=0 outside FULL. The sorter then passes data through, and downstream logic must ignore its output.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - state=IDLE, `idx`=0, `in_ready`=1, `out_valid`=0, `ena`=0.
  - `desordenado`=0, `cresc_ou_decres`=1, `count`=0.
- Reset mid-frame or while FULL discards the frame; no partial output appears.
- `in_ready` and `out_valid` are registered-state decodes: no combinational path from `in_valid` or `out_ready`.
- Latency: `out_valid` rises on the edge that accepts the final byte, so it is visible the following cycle.
- Throughput: 8 input cycles plus at least 1 FULL cycle per frame.
  - No byte is accepted in the cycle `out_ready` is sampled; `in_ready` rises the cycle after.
- `out_ready` asserted while not FULL is ignored.
- `in_valid` while FULL is ignored, with no data loss: the producer holds the byte because `in_ready`=0.

## Configuration
- Macro: `COLETA_PAD_EN`.
- Defined (short frames supported):
  - A handshake with `in_last`=1 ends the frame early and sets `count`=`idx`+1.
  - Unwritten slots are filled with `PAD_CRESC` if the latched direction is 1, else `PAD_DECRES`, so pads sort to the tail.
  - All pad slots are written in the same edge as the final byte, and the state moves to FULL.
  - `in_last` on the 8th byte behaves as a normal full frame.
- Undefined: `in_last` is ignored, every frame is exactly 8 bytes, and `count` is always 8 when FULL.

## Test plan
- Reset check: hold `rst_n`=0 for 2 cycles, then release -> `in_ready`=1, `out_valid`=0, `ena`=0, `desordenado`=0, `count`=0.
- Full frame: `in_cresc`=1 on the first byte; send bytes 5,3,9,1,8,2,7,4 back-to-back -> one cycle after the 8th byte, `out_valid`=`ena`=1, slot0=5 … slot7=4, `cresc_ou_decres`=1, `count`=8.
- Backpressure: hold `out_ready`=0 for 10 cycles while `in_valid`=1 with data 8'hAA:
  - `in_ready`=0 throughout and the frame is unchanged.
  - When `out_ready` is pulsed, `out_valid` falls; the next byte, 8'hAA, lands in slot 0 of the new frame.
- Direction latch: `in_cresc`=0 on the first byte, toggling on later bytes -> `cresc_ou_decres`=0 for the whole frame.
- Reset mid-frame: assert `rst_n`=0 after 4 bytes -> `idx`=0, and a fresh 8-byte frame then completes correctly.
- Pad (`COLETA_PAD_EN`): with `in_cresc`=1, send 6,2,4 with `in_last` on the 3rd byte -> slots = 6,2,4,FF,FF,FF,FF,FF, `count`=3. With `in_cresc`=0 the pad slots are 00.
